// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: runs a single outstanding memory request with a timeout,
// freezes the pipeline while the request is in flight, and registers the write-back bundle.
module mem_wb_stage #(
  parameter logic [31:0] MEM_BASE = 32'd1024,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_EN_IN,
  input  logic        MEM_R_EN_IN,
  input  logic        MEM_W_EN_IN,
  input  logic [31:0] ALU_Res_IN,
  input  logic [31:0] VAL_RM_IN,
  input  logic [3:0]  Dest_IN,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        freeze,
  output logic        WB_EN,
  output logic        MEM_R_EN,
  output logic [31:0] ALU_Res,
  output logic [31:0] Mem_Res,
  output logic [3:0]  Dest,
  output logic        mem_err
);
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 4;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt, wait_cnt_next, wait_inc;
  logic [DW-1:0] addr_q, addr_next;
  logic [DW-1:0] wdata_q, wdata_next;
  logic [DW-1:0] rbuf, rbuf_next;
  logic          we_q, we_next;
  logic          err_next;
  logic          access;

  assign access   = MEM_R_EN_IN | MEM_W_EN_IN;
  assign wait_inc = wait_cnt + CW'(1);

  // State, captured request and sticky error registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      rbuf     <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      addr_q   <= addr_next;
      wdata_q  <= wdata_next;
      we_q     <= we_next;
      rbuf     <= rbuf_next;
      mem_err  <= err_next;
    end
  end

  // Next state and memory-side / freeze outputs
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    addr_next     = addr_q;
    wdata_next    = wdata_q;
    we_next       = we_q;
    rbuf_next     = rbuf;
    err_next      = mem_err;
    freeze        = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    case (state)
      IDLE: begin
        freeze = access;
        if (access) begin
          addr_next     = ALU_Res_IN - MEM_BASE;
          wdata_next    = VAL_RM_IN;
          we_next       = MEM_W_EN_IN & ~MEM_R_EN_IN;
          wait_cnt_next = '0;
          state_next    = ACCESS;
        end
      end
      ACCESS: begin
        freeze    = 1'b1;
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (mem_ready) begin
          rbuf_next  = mem_rdata;
          state_next = DONE;
        end else begin
          wait_cnt_next = wait_inc;
          if (wait_inc == TIMEOUT) begin
            err_next   = 1'b1;
            rbuf_next  = '0;
            state_next = DONE;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Write-back register: advances whenever the pipeline is not frozen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WB_EN    <= 1'b0;
      MEM_R_EN <= 1'b0;
      ALU_Res  <= '0;
      Mem_Res  <= '0;
      Dest     <= RW'(0);
    end else if (!freeze) begin
      WB_EN    <= WB_EN_IN;
      MEM_R_EN <= MEM_R_EN_IN;
      ALU_Res  <= ALU_Res_IN;
      Dest     <= Dest_IN;
      Mem_Res  <= (state == DONE && !we_q) ? rbuf : '0;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: driver pushes expected write-back bundles and
// memory requests, a memory model and a write-back monitor pop and compare.
module tb_mem_wb_stage;
  localparam logic [31:0] MEM_BASE = 32'd1024;
  localparam logic [7:0]  TIMEOUT  = 8'd255;

  logic        clk = 1'b0;
  logic        rst;
  logic        WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN;
  logic [31:0] ALU_Res_IN, VAL_RM_IN;
  logic [3:0]  Dest_IN;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_req, mem_we, freeze;
  logic [31:0] mem_addr, mem_wdata;
  logic        WB_EN, MEM_R_EN, mem_err;
  logic [31:0] ALU_Res, Mem_Res;
  logic [3:0]  Dest;

  mem_wb_stage #(.MEM_BASE(MEM_BASE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .WB_EN_IN(WB_EN_IN), .MEM_R_EN_IN(MEM_R_EN_IN), .MEM_W_EN_IN(MEM_W_EN_IN),
    .ALU_Res_IN(ALU_Res_IN), .VAL_RM_IN(VAL_RM_IN), .Dest_IN(Dest_IN),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .freeze(freeze),
    .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .ALU_Res(ALU_Res), .Mem_Res(Mem_Res),
    .Dest(Dest), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wb, r, w;
    logic [31:0] alu, val;
    logic [3:0]  dest;
    int          lat;     // ACCESS cycle on which memory answers; 0 = never
    logic [31:0] rdata;
  } instr_t;

  typedef struct {
    logic        wb, r;
    logic [31:0] alu, mres;
    logic [3:0]  dest;
    logic        err;
  } exp_t;

  typedef struct {
    logic [31:0] addr, wdata, rdata;
    logic        we;
    int          lat;
  } req_t;

  exp_t exp_q[$];
  req_t req_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic err_m = 1'b0;
  logic done = 1'b0;
  logic ld;
  exp_t mon_e;
  req_t mcur;
  int   mk = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  function automatic instr_t mk_i(logic wb, logic r, logic w, logic [31:0] alu,
                                  logic [31:0] val, logic [3:0] dest, int lat,
                                  logic [31:0] rdata);
    instr_t t;
    t.wb = wb; t.r = r; t.w = w; t.alu = alu; t.val = val;
    t.dest = dest; t.lat = lat; t.rdata = rdata;
    return t;
  endfunction

  // Called at a falling edge; returns at the falling edge after the instruction is accepted
  task automatic issue(input instr_t t);
    int     frozen = 0;
    int     exp_frz;
    logic   acc;
    exp_t   e;
    req_t   q;
    WB_EN_IN = t.wb; MEM_R_EN_IN = t.r; MEM_W_EN_IN = t.w;
    ALU_Res_IN = t.alu; VAL_RM_IN = t.val; Dest_IN = t.dest;
    acc = t.r | t.w;
    e.mres = 32'h0;
    if (acc) begin
      q.addr = t.alu - MEM_BASE;
      q.we = t.w && !t.r;
      q.wdata = t.val;
      q.lat = t.lat;
      q.rdata = t.rdata;
      req_q.push_back(q);
      if (t.lat == 0) err_m = 1'b1;
      else if (t.r) e.mres = t.rdata;
    end
    e.wb = t.wb; e.r = t.r; e.alu = t.alu; e.dest = t.dest; e.err = err_m;
    exp_q.push_back(e);
    exp_frz = !acc ? 0 : (t.lat == 0 ? int'(TIMEOUT) + 1 : t.lat + 1);
    forever begin
      #4;
      if (!freeze) break;
      frozen++;
      if (frozen > 400) begin
        vectors++; miscompares++;
        $display("FAIL accept_timeout: freeze still high after %0d cycles", frozen);
        break;
      end
      @(negedge clk);
    end
    check("freeze_cycles", 32'(frozen), 32'(exp_frz));
    @(negedge clk);
  endtask

  // Memory model: checks the request bus and answers after the requested latency
  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        mk++;
        if (mk == 1) begin
          if (req_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL mem_req_unexpected: got request addr %h expected none", mem_addr);
            mcur = '{addr: 32'h0, wdata: 32'h0, rdata: 32'h0, we: 1'b0, lat: 0};
          end else begin
            mcur = req_q.pop_front();
          end
        end
        check("mem_addr", mem_addr, mcur.addr);
        check("mem_we", 32'(mem_we), 32'(mcur.we));
        check("mem_wdata", mem_wdata, mcur.wdata);
        if (mk == mcur.lat) begin
          mem_ready = 1'b1;
          mem_rdata = mcur.rdata;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
        end
      end else begin
        mk = 0;
        check("idle_bus", {mem_addr[30:0], mem_we}, 32'h0);
        check("idle_wdata", mem_wdata, 32'h0);
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
    end
  end

  // Write-back monitor: every unfrozen edge must deliver the next expected bundle
  initial begin
    forever begin
      @(negedge clk);
      #4;
      ld = !freeze && !rst && !done;
      @(posedge clk);
      #1;
      if (ld) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL wb_unexpected: got ALU_Res %h expected no write-back", ALU_Res);
        end else begin
          mon_e = exp_q.pop_front();
          check("WB_EN", 32'(WB_EN), 32'(mon_e.wb));
          check("MEM_R_EN", 32'(MEM_R_EN), 32'(mon_e.r));
          check("ALU_Res", ALU_Res, mon_e.alu);
          check("Mem_Res", Mem_Res, mon_e.mres);
          check("Dest", 32'(Dest), 32'(mon_e.dest));
          check("mem_err", 32'(mem_err), 32'(mon_e.err));
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, {29'h0, mem_req, mem_we, 1'b0}, 32'h0);
    check({tag, "_addr"}, mem_addr, 32'h0);
    check({tag, "_wdata"}, mem_wdata, 32'h0);
    check({tag, "_wb"}, {26'h0, WB_EN, MEM_R_EN, Dest}, 32'h0);
    check({tag, "_alu"}, ALU_Res, 32'h0);
    check({tag, "_memres"}, Mem_Res, 32'h0);
    check({tag, "_err"}, 32'(mem_err), 32'h0);
  endtask

  instr_t t;
  int     kind;

  initial begin
    rst = 1'b1;
    WB_EN_IN = 1'b0; MEM_R_EN_IN = 1'b0; MEM_W_EN_IN = 1'b0;
    ALU_Res_IN = 32'h0; VAL_RM_IN = 32'h0; Dest_IN = 4'h0;
    #3;
    check_all_zero("reset");
    check("reset_freeze", 32'(freeze), 32'h0);
    @(posedge clk); #2; rst = 1'b0;
    @(negedge clk);

    issue(mk_i(1, 0, 0, 32'h0000_0010, 32'h0, 4'd3, 0, 32'h0));               // ALU op
    issue(mk_i(0, 0, 1, 32'd1032, 32'hCAFE_F00D, 4'd1, 3, 32'h5555_AAAA));     // store
    issue(mk_i(1, 1, 0, 32'd1024, 32'h0, 4'd2, 1, 32'h1234_5678));             // load
    issue(mk_i(1, 1, 1, 32'd1028, 32'h7777_0000, 4'd4, 2, 32'h0BAD_F00D));     // both set
    issue(mk_i(1, 1, 0, 32'd4, 32'h0, 4'd6, 1, 32'h0000_0042));                // wrapping addr
    issue(mk_i(1, 1, 0, MEM_BASE + 32'd16, 32'h0, 4'd7, 0, 32'hDEAD_BEEF));   // timeout
    issue(mk_i(1, 0, 0, 32'h0000_0020, 32'h0, 4'd8, 0, 32'h0));
    issue(mk_i(1, 0, 0, 32'h0000_0030, 32'h0, 4'd9, 0, 32'h0));

    // Reset in the middle of a pending load
    WB_EN_IN = 1'b1; MEM_R_EN_IN = 1'b1; MEM_W_EN_IN = 1'b0;
    ALU_Res_IN = MEM_BASE + 32'd100; VAL_RM_IN = 32'h0; Dest_IN = 4'd5;
    req_q.push_back('{addr: 32'd100, wdata: 32'h0, rdata: 32'h0, we: 1'b0, lat: 0});
    repeat (3) @(negedge clk);
    #2; rst = 1'b1;
    #1;
    check_all_zero("midreset");
    check("midreset_freeze", 32'(freeze), 32'h1);
    @(posedge clk); #2;
    rst = 1'b0;
    WB_EN_IN = 1'b0; MEM_R_EN_IN = 1'b0; ALU_Res_IN = 32'h0; Dest_IN = 4'h0;
    err_m = 1'b0;
    @(negedge clk);
    issue(mk_i(1, 0, 0, 32'h0000_0010, 32'h0, 4'd3, 0, 32'h0));

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 4);
      t.wb = 1'($urandom_range(0, 1));
      t.r = (kind == 2 || kind == 4);
      t.w = (kind == 3 || kind == 4);
      t.alu = ($urandom_range(0, 3) == 0) ? $urandom : MEM_BASE + 32'($urandom_range(0, 4095));
      t.val = $urandom;
      t.dest = 4'($urandom);
      t.lat = $urandom_range(1, 5);
      t.rdata = $urandom;
      issue(t);
    end
    issue(mk_i(0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0));
    done = 1'b1;
    repeat (3) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    check("req_q_drained", 32'(req_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
